// File: rtl/dm_pkg.sv
// Shared types for the data-memory store path.
// Width encodings and the store-buffer entry layout.
package dm_pkg;

  localparam logic [1:0] W_WORD = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_BYTE = 2'd2;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  byteen;
    logic [31:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Width/offset decode to byte enables and lane-aligned data.
// Shared by the store buffer and the load extension unit.
module store_align
  import dm_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic [31:0] data,
  output logic [3:0]  byteen,
  output logic [31:0] lane_data,
  output logic        misalign
);

  always_comb begin
    byteen    = '0;
    lane_data = '0;
    misalign  = 1'b0;
    unique case (1'b1)
      (width == W_WORD): begin
        misalign  = (offset != 2'b00);
        byteen    = 4'b1111;
        lane_data = data;
      end
      (width == W_HALF): begin
        misalign  = offset[0];
        byteen    = 4'b0011 << offset;
        lane_data = {16'b0, data[15:0]} << {offset[1], 4'b0};
      end
      (width == W_BYTE): begin
        byteen    = 4'b0001 << offset;
        lane_data = {24'b0, data[7:0]} << {offset, 3'b0};
      end
      default: misalign = 1'b1;
    endcase
    if (misalign) begin
      byteen    = '0;
      lane_data = '0;
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Coalescing store buffer between MEM stores and data memory,
// with per-byte store-to-load forwarding.
module dm_store_buffer
  import dm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_width,
  input  logic [31:0] st_data,
  input  logic [31:0] st_pc,
  output logic        st_misalign,
  input  logic [31:0] ld_addr,
  output logic [3:0]  ld_fwd_mask,
  output logic [31:0] ld_fwd_data,
  output logic        dm_we,
  input  logic        dm_ready,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  output logic [31:0] dm_pc,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    last;
  logic [CNT_W-1:0] count;

  logic [3:0]  a_be;
  logic [31:0] a_data;
  logic        a_mis;

  logic      pop;
  logic      coal;
  logic      accept;
  logic      push;
  logic      merge;
  sb_entry_t merged;
  logic      unused;

  store_align u_align (
    .offset    (st_addr[1:0]),
    .width     (st_width),
    .data      (st_data),
    .byteen    (a_be),
    .lane_data (a_data),
    .misalign  (a_mis)
  );

  assign unused = ^ld_addr[1:0];

  assign last        = tail - PW'(1);
  assign st_misalign = st_valid && a_mis;
  assign dm_we       = (count != '0);
  assign empty       = (count == '0);
  assign pop         = dm_we && dm_ready;

  // Never merge into a head that leaves this cycle.
  assign coal = (count != '0)
             && (ent[last].waddr == st_addr[31:2])
             && !((count == CNT_W'(1)) && pop);

  assign st_ready = coal || (count < CNT_W'(DEPTH));
  assign accept   = st_valid && !a_mis && st_ready;
  assign push     = accept && !coal;
  assign merge    = accept && coal;

  assign dm_addr   = dm_we ? {ent[head].waddr, 2'b00} : '0;
  assign dm_wdata  = dm_we ? ent[head].data : '0;
  assign dm_byteen = dm_we ? ent[head].byteen : '0;
  assign dm_pc     = dm_we ? ent[head].pc : '0;

  always_comb begin
    merged        = ent[last];
    merged.byteen = ent[last].byteen | a_be;
    merged.pc     = st_pc;
    for (int l = 0; l < 4; l++) begin
      if (a_be[l]) begin
        merged.data[8*l +: 8] = a_data[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (pop) begin
        head      <= head + PW'(1);
        vld[head] <= 1'b0;
      end
      if (push) begin
        tail      <= tail + PW'(1);
        vld[tail] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent[tail] <= '{waddr:  st_addr[31:2],
                     data:   a_data,
                     byteen: a_be,
                     pc:     st_pc};
    end else if (merge) begin
      ent[last] <= merged;
    end
  end

  // Walk oldest to youngest so younger bytes override older ones.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = head;
    ld_fwd_mask = '0;
    ld_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (vld[idx] && (ent[idx].waddr == ld_addr[31:2])) begin
        for (int l = 0; l < 4; l++) begin
          if (ent[idx].byteen[l]) begin
            ld_fwd_mask[l]         = 1'b1;
            ld_fwd_data[8*l +: 8]  = ent[idx].data[8*l +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer.
// Directed stores; a monitor checks every DM write in order.
module tb_dm_store_buffer;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [1:0]  st_width = '0;
  logic [31:0] st_data = '0;
  logic [31:0] st_pc = '0;
  logic        st_misalign;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_fwd_mask;
  logic [31:0] ld_fwd_data;
  logic        dm_we;
  logic        dm_ready = 1'b0;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_pc;
  logic        empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  dm_store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_width    (st_width),
    .st_data     (st_data),
    .st_pc       (st_pc),
    .st_misalign (st_misalign),
    .ld_addr     (ld_addr),
    .ld_fwd_mask (ld_fwd_mask),
    .ld_fwd_data (ld_fwd_data),
    .dm_we       (dm_we),
    .dm_ready    (dm_ready),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_byteen   (dm_byteen),
    .dm_pc       (dm_pc),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d, input logic [31:0] pc);
    exp_t e;
    e.addr = a;
    e.be   = be;
    e.data = d;
    e.pc   = pc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] w,
                       input logic [31:0] d, input logic [31:0] pc);
    st_valid = 1'b1;
    st_addr  = a;
    st_width = w;
    st_data  = d;
    st_pc    = pc;
    @(negedge clk);
    chk($sformatf("st_ready@%0h", a), {31'b0, st_ready}, 32'd1);
    cyc();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int max);
    int n;
    n = 0;
    while (!empty && n < max) begin
      cyc();
      n++;
    end
    chk(name, {31'b0, empty}, 32'd1);
    chk({name, "_sb"}, sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && dm_we && dm_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL dm_write: got unexpected addr=0x%08h be=%b data=0x%08h",
                 dm_addr, dm_byteen, dm_wdata);
      end else begin
        e = sb.pop_front();
        if (dm_addr !== e.addr || dm_byteen !== e.be ||
            dm_wdata !== e.data || dm_pc !== e.pc) begin
          errors++;
          $display("FAIL dm_write: got %08h/%b/%08h/%08h want %08h/%b/%08h/%08h",
                   dm_addr, dm_byteen, dm_wdata, dm_pc,
                   e.addr, e.be, e.data, e.pc);
        end
      end
    end
  end

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_we", {31'b0, dm_we}, 0);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_st_ready", {31'b0, st_ready}, 1);
    chk("rst_byteen", {28'b0, dm_byteen}, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_pc", dm_pc, 0);
    chk("rst_fwd_mask", {28'b0, ld_fwd_mask}, 0);
    reset = 1'b1;
    cyc();

    // 1: three stores to separate words, streaming drain
    dm_ready = 1'b1;
    expect_wr(32'h10, 4'b1111, 32'h11223344, 32'h1000);
    expect_wr(32'h20, 4'b1100, 32'hABCD0000, 32'h1004);
    expect_wr(32'h30, 4'b1000, 32'hEE000000, 32'h1008);
    issue(32'h10, W_WORD, 32'h11223344, 32'h1000);
    issue(32'h22, W_HALF, 32'h0000ABCD, 32'h1004);
    issue(32'h33, W_BYTE, 32'h000000EE, 32'h1008);
    wait_empty("t1_empty", 20);

    // 2: coalescing into a stalled head
    dm_ready = 1'b0;
    issue(32'h40, W_BYTE, 32'hAA, 32'h2000);
    issue(32'h41, W_BYTE, 32'hBB, 32'h2004);
    issue(32'h42, W_HALF, 32'hCCDD, 32'h2008);
    @(negedge clk);
    chk("t2_dm_we", {31'b0, dm_we}, 1);
    chk("t2_addr", dm_addr, 32'h40);
    chk("t2_byteen", {28'b0, dm_byteen}, 32'hF);
    chk("t2_wdata", dm_wdata, 32'hCCDDBBAA);
    chk("t2_pc", dm_pc, 32'h2008);
    cyc();
    expect_wr(32'h40, 4'b1111, 32'hCCDDBBAA, 32'h2008);
    dm_ready = 1'b1;
    cyc();
    dm_ready = 1'b0;
    @(negedge clk);
    chk("t2_single_entry", {31'b0, empty}, 1);
    cyc();

    // 3: full buffer, tail coalesce, one slot freed per cycle
    for (int k = 0; k < 4; k++) begin
      if (k < 3)
        expect_wr(32'h100 + 4 * k, 4'b1111, 32'hA0000000 + k, 32'h3000 + 4 * k);
      issue(32'h100 + 4 * k, W_WORD, 32'hA0000000 + k, 32'h3000 + 4 * k);
    end
    st_valid = 1'b1;
    st_addr  = 32'h110;
    st_width = W_WORD;
    st_data  = 32'h000000B4;
    st_pc    = 32'h3010;
    @(negedge clk);
    chk("t3_full_stall", {31'b0, st_ready}, 0);
    cyc();
    issue(32'h10F, W_BYTE, 32'h77, 32'h3014);
    expect_wr(32'h10C, 4'b1111, 32'h77000003, 32'h3014);
    expect_wr(32'h110, 4'b1111, 32'h000000B4, 32'h3010);
    st_valid = 1'b1;
    st_addr  = 32'h110;
    st_width = W_WORD;
    st_data  = 32'h000000B4;
    st_pc    = 32'h3010;
    dm_ready = 1'b1;
    @(negedge clk);
    chk("t3_no_reuse", {31'b0, st_ready}, 0);
    cyc();
    @(negedge clk);
    chk("t3_slot_freed", {31'b0, st_ready}, 1);
    cyc();
    st_valid = 1'b0;
    wait_empty("t3_empty", 20);

    // 4: forwarding, youngest byte wins
    dm_ready = 1'b0;
    issue(32'h81, W_BYTE, 32'h5A, 32'h4000);
    issue(32'h80, W_HALF, 32'h1234, 32'h4004);
    issue(32'h85, W_BYTE, 32'h99, 32'h4008);
    issue(32'h80, W_BYTE, 32'h66, 32'h400C);
    ld_addr = 32'h80;
    @(negedge clk);
    chk("t4_mask_80", {28'b0, ld_fwd_mask}, 32'h3);
    chk("t4_data_80", ld_fwd_data, 32'h00001266);
    cyc();
    ld_addr = 32'h86;
    @(negedge clk);
    chk("t4_mask_84", {28'b0, ld_fwd_mask}, 32'h2);
    chk("t4_data_84", ld_fwd_data, 32'h00009900);
    cyc();
    ld_addr = 32'h88;
    @(negedge clk);
    chk("t4_mask_miss", {28'b0, ld_fwd_mask}, 32'h0);
    chk("t4_data_miss", ld_fwd_data, 32'h0);
    cyc();
    st_valid = 1'b1;
    st_addr  = 32'h8C;
    st_width = W_BYTE;
    st_data  = 32'h42;
    st_pc    = 32'h4010;
    ld_addr  = 32'h8C;
    @(negedge clk);
    chk("t4_same_cycle", {28'b0, ld_fwd_mask}, 32'h0);
    cyc();
    st_valid = 1'b0;
    @(negedge clk);
    chk("t4_next_mask", {28'b0, ld_fwd_mask}, 32'h1);
    chk("t4_next_data", ld_fwd_data, 32'h42);
    cyc();
    expect_wr(32'h80, 4'b0011, 32'h00001234, 32'h4004);
    expect_wr(32'h84, 4'b0010, 32'h00009900, 32'h4008);
    expect_wr(32'h80, 4'b0001, 32'h00000066, 32'h400C);
    expect_wr(32'h8C, 4'b0001, 32'h00000042, 32'h4010);
    dm_ready = 1'b1;
    wait_empty("t4_empty", 20);

    // 5: misaligned stores never touch the buffer
    dm_ready = 1'b0;
    issue(32'h200, W_WORD, 32'h55, 32'h5000);
    for (int v = 0; v < 3; v++) begin
      st_valid = 1'b1;
      st_addr  = (v == 0) ? 32'h206 : (v == 1) ? 32'h203 : 32'h200;
      st_width = (v == 0) ? W_WORD : (v == 1) ? W_HALF : 2'd3;
      st_data  = 32'hFFFFFFFF;
      st_pc    = 32'h5100 + v;
      @(negedge clk);
      chk($sformatf("t5_misalign_%0d", v), {31'b0, st_misalign}, 1);
      cyc();
      st_valid = 1'b0;
    end
    @(negedge clk);
    chk("t5_misalign_idle", {31'b0, st_misalign}, 0);
    chk("t5_head_addr", dm_addr, 32'h200);
    chk("t5_head_data", dm_wdata, 32'h55);
    chk("t5_head_pc", dm_pc, 32'h5000);
    cyc();
    expect_wr(32'h200, 4'b1111, 32'h55, 32'h5000);
    dm_ready = 1'b1;
    cyc();
    dm_ready = 1'b0;
    @(negedge clk);
    chk("t5_count_one", {31'b0, empty}, 1);
    cyc();

    // 6: reset while draining is pending
    issue(32'h300, W_WORD, 32'h1, 32'h6000);
    issue(32'h304, W_WORD, 32'h2, 32'h6004);
    issue(32'h308, W_WORD, 32'h3, 32'h6008);
    ld_addr = 32'h300;
    @(negedge clk);
    chk("t6_dm_we_pre", {31'b0, dm_we}, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_dm_we", {31'b0, dm_we}, 0);
    chk("t6_empty", {31'b0, empty}, 1);
    chk("t6_byteen", {28'b0, dm_byteen}, 0);
    chk("t6_addr", dm_addr, 0);
    chk("t6_fwd_mask", {28'b0, ld_fwd_mask}, 0);
    chk("t6_st_ready", {31'b0, st_ready}, 1);
    cyc();
    reset    = 1'b1;
    dm_ready = 1'b1;
    repeat (8) cyc();
    chk("t6_still_empty", {31'b0, empty}, 1);
    chk("t6_sb", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
